// File: rtl/johnson_decoder.sv
// ============================================================================
// johnson_decoder
// ----------------------------------------------------------------------------
// Purpose:
//   Samples an N-bit Johnson-coded word, decodes it to a binary phase index
//   on the 2N-state ring, flags codes that are not Johnson states, and
//   checks that successive legal samples advance exactly one ring position.
//   After LOCK_CNT consecutive in-sequence legal samples the decoder reports
//   lock; any illegal code or sequence break drops lock again.
//
// Parameters:
//   N         Johnson code width (ring length 2N), N >= 2
//   LOCK_CNT  consecutive in-sequence legal samples needed for lock, 1..15
//   PW        derived phase width, clog2(2N)
//
// Ports:
//   CLK          in   1   clock, all state updates on the rising edge
//   RESET        in   1   synchronous active-high reset
//   I            in   N   Johnson-coded sample, I[0] is the shift-in end
//   I_valid      in   1   I is sampled this cycle
//   phase        out  PW  decoded phase index 0..2N-1
//   phase_valid  out  1   one-cycle pulse, phase is valid
//   illegal      out  1   one-cycle pulse, sample was not a Johnson state
//   seq_err      out  1   one-cycle pulse, legal sample was not the successor
//   locked       out  1   level, lock achieved
//   err_count    out  16  saturating count of error cycles
//
// Build option:
//   JOHNSON_DEC_ERRCNT_EN  when defined, err_count counts every cycle in
//                          which illegal or seq_err is high (saturating at
//                          16'hFFFF). When undefined, err_count is tied to 0.
// ============================================================================
module johnson_decoder #(
    parameter int N        = 4,
    parameter int LOCK_CNT = 3,
    localparam int PW      = $clog2(2 * N)
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic [N-1:0]  I,
    input  logic          I_valid,
    output logic [PW-1:0] phase,
    output logic          phase_valid,
    output logic          illegal,
    output logic          seq_err,
    output logic          locked,
    output logic [15:0]   err_count
);

    localparam logic [0:0] ST_SEARCH = 1'b0;
    localparam logic [0:0] ST_LOCKED = 1'b1;
    localparam logic [3:0] LOCK_Q    = 4'(LOCK_CNT);

    // ------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------
    logic [PW-1:0] phase_q,       phase_d;
    logic          phase_valid_q, phase_valid_d;
    logic          illegal_q,     illegal_d;
    logic          seq_err_q,     seq_err_d;
    logic [PW-1:0] prev_phase_q,  prev_phase_d;
    logic          prev_ok_q,     prev_ok_d;
    logic [3:0]    lock_ctr_q,    lock_ctr_d;
    logic [0:0]    state_q,       state_d;

    // ------------------------------------------------------------------
    // Decode: popcount gives the phase directly in the first half of the
    // ring (MSB clear) and 2N - popcount in the second half.
    // ------------------------------------------------------------------
    int            dec_int;
    logic [PW-1:0] dec_phase;
    logic [N-1:0]  canon;
    logic          legal;

    always_comb begin
        int pc_int;
        pc_int = 0;
        for (int b = 0; b < N; b++) begin
            if (I[b]) pc_int = pc_int + 1;
        end
        dec_int   = I[N-1] ? (2 * N - pc_int) : pc_int;
        dec_phase = dec_int[PW-1:0];
    end

    // Rebuild the canonical pattern of the decoded phase; the sample is
    // legal only if it matches bit for bit. First half: k low ones.
    // Second half: (k-N) low zeros, ones above.
    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_canon
            assign canon[gi] = (dec_int <= N) ? (gi < dec_int)
                                              : (gi >= dec_int - N);
        end
    endgenerate

    assign legal = (canon == I);

    // Expected next phase, wrapping 2N-1 back to 0.
    logic [PW-1:0] succ;
    assign succ = (int'(prev_phase_q) == 2 * N - 1) ? '0 : prev_phase_q + 1'b1;

    // Saturating increment of the run counter.
    logic [3:0] lock_ctr_inc;
    assign lock_ctr_inc = (lock_ctr_q >= LOCK_Q) ? LOCK_Q : lock_ctr_q + 4'd1;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        phase_d       = phase_q;
        phase_valid_d = 1'b0;
        illegal_d     = 1'b0;
        seq_err_d     = 1'b0;
        prev_phase_d  = prev_phase_q;
        prev_ok_d     = prev_ok_q;
        lock_ctr_d    = lock_ctr_q;
        state_d       = state_q;

        if (I_valid) begin
            if (!legal) begin
                // phase keeps its previous value on an illegal sample
                illegal_d  = 1'b1;
                prev_ok_d  = 1'b0;
                lock_ctr_d = 4'd0;
                state_d    = ST_SEARCH;
            end else begin
                phase_d       = dec_phase;
                phase_valid_d = 1'b1;
                prev_phase_d  = dec_phase;
                prev_ok_d     = 1'b1;
                if (!prev_ok_q) begin
                    // First legal sample after reset or an illegal code
                    lock_ctr_d = 4'd1;
                    state_d    = (LOCK_Q == 4'd1) ? ST_LOCKED : ST_SEARCH;
                end else if (dec_phase == succ) begin
                    lock_ctr_d = lock_ctr_inc;
                    if (lock_ctr_inc == LOCK_Q) state_d = ST_LOCKED;
                end else begin
                    // Includes a repeated phase (no advance)
                    seq_err_d  = 1'b1;
                    lock_ctr_d = 4'd1;
                    state_d    = ST_SEARCH;
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            phase_q       <= '0;
            phase_valid_q <= 1'b0;
            illegal_q     <= 1'b0;
            seq_err_q     <= 1'b0;
            prev_phase_q  <= '0;
            prev_ok_q     <= 1'b0;
            lock_ctr_q    <= 4'd0;
            state_q       <= ST_SEARCH;
        end else begin
            phase_q       <= phase_d;
            phase_valid_q <= phase_valid_d;
            illegal_q     <= illegal_d;
            seq_err_q     <= seq_err_d;
            prev_phase_q  <= prev_phase_d;
            prev_ok_q     <= prev_ok_d;
            lock_ctr_q    <= lock_ctr_d;
            state_q       <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Error counter: counts cycles in which an error pulse is visible
    // ------------------------------------------------------------------
`ifdef JOHNSON_DEC_ERRCNT_EN
    logic [15:0] err_cnt_q, err_cnt_d;

    always_comb begin
        err_cnt_d = err_cnt_q;
        if ((illegal_q || seq_err_q) && (err_cnt_q != 16'hFFFF)) begin
            err_cnt_d = err_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) err_cnt_q <= 16'd0;
        else       err_cnt_q <= err_cnt_d;
    end

    assign err_count = err_cnt_q;
`else
    assign err_count = 16'd0;
`endif

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign phase       = phase_q;
    assign phase_valid = phase_valid_q;
    assign illegal     = illegal_q;
    assign seq_err     = seq_err_q;
    assign locked      = (state_q == ST_LOCKED);

endmodule

// File: tb/tb_johnson_decoder.sv
// ============================================================================
// tb_johnson_decoder
// ----------------------------------------------------------------------------
// Drives johnson_decoder (N=4, LOCK_CNT=3) with the directed scenarios of
// the design description followed by random traffic, and compares every
// output after each clock edge against a reference model. The model decodes
// by looking the sample up in a table of ring patterns and tracks lock as
// the length of the current run of in-sequence legal samples.
// ============================================================================
module tb_johnson_decoder;

    localparam int N        = 4;
    localparam int LOCK_CNT = 3;
    localparam int PW       = 3;
    localparam int RING     = 2 * N;

    logic          CLK = 1'b0;
    logic          RESET;
    logic [N-1:0]  I;
    logic          I_valid;
    logic [PW-1:0] phase;
    logic          phase_valid;
    logic          illegal;
    logic          seq_err;
    logic          locked;
    logic [15:0]   err_count;

    johnson_decoder #(.N(N), .LOCK_CNT(LOCK_CNT)) dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .I           (I),
        .I_valid     (I_valid),
        .phase       (phase),
        .phase_valid (phase_valid),
        .illegal     (illegal),
        .seq_err     (seq_err),
        .locked      (locked),
        .err_count   (err_count)
    );

    always #5 CLK = ~CLK;

    int tests = 0;
    int fails = 0;

    // Ring pattern table built from the code-map rule
    int ring [RING];

    // Reference model state and expected outputs
    int  m_prev;
    bit  m_prev_ok;
    int  m_run;
    int  e_phase;
    bit  e_pv, e_ill, e_seq, e_locked;
    int  e_err;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int lookup(input logic [N-1:0] code);
        int k;
        k = -1;
        for (int j = 0; j < RING; j++) begin
            if (int'(code) == ring[j]) k = j;
        end
        return k;
    endfunction

    task automatic model_reset();
        m_prev = 0; m_prev_ok = 0; m_run = 0;
        e_phase = 0; e_pv = 0; e_ill = 0; e_seq = 0; e_locked = 0; e_err = 0;
    endtask

    // One clock: apply inputs, advance the model, compare all outputs.
    task automatic step(input logic [N-1:0] code, input bit v, input bit rst);
        int k;
        I = code; I_valid = v; RESET = rst;
        @(posedge CLK);
        #1;
        if (rst) begin
            model_reset();
        end else begin
`ifdef JOHNSON_DEC_ERRCNT_EN
            if ((e_ill || e_seq) && e_err != 16'hFFFF) e_err++;
`endif
            e_ill = 0; e_seq = 0; e_pv = 0;
            if (v) begin
                k = lookup(code);
                if (k < 0) begin
                    e_ill = 1; m_prev_ok = 0; m_run = 0; e_locked = 0;
                end else begin
                    e_pv = 1; e_phase = k;
                    if (!m_prev_ok)                     m_run = 1;
                    else if (k == (m_prev + 1) % RING)  m_run++;
                    else begin
                        e_seq = 1; m_run = 1; e_locked = 0;
                    end
                    m_prev = k; m_prev_ok = 1;
                    if (!e_seq && m_run >= LOCK_CNT) e_locked = 1;
                end
            end
        end
        $display("[TB] rst=%0b v=%0b I=%b -> phase=%0d pv=%0b ill=%0b seq=%0b lock=%0b err=%0d",
                 rst, v, code, phase, phase_valid, illegal, seq_err, locked, err_count);
        check("phase_valid", 32'(phase_valid), 32'(e_pv));
        check("illegal",     32'(illegal),     32'(e_ill));
        check("seq_err",     32'(seq_err),     32'(e_seq));
        check("locked",      32'(locked),      32'(e_locked));
        check("phase",       32'(phase),       32'(e_phase));
        check("err_count",   32'(err_count),   32'(e_err));
        check("ill_seq_excl", 32'(illegal & seq_err), 32'd0);
    endtask

    initial begin
        int r, r2;
        logic [N-1:0] c;
        bit v;

        for (int k = 0; k < RING; k++) begin
            if (k <= N) ring[k] = (1 << k) - 1;
            else        ring[k] = (((1 << N) - 1) << (k - N)) & ((1 << N) - 1);
        end

        I = '0; I_valid = 0; RESET = 1;
        model_reset();

        // Reset state
        step(4'b0000, 0, 1);
        step(4'b0000, 0, 1);

        // Lock on 0000, 0001, 0011
        step(4'b0000, 1, 0);
        step(4'b0001, 1, 0);
        step(4'b0011, 1, 0);
        // Full ring with wrap-around 1000 -> 0000
        step(4'b0111, 1, 0);
        step(4'b1111, 1, 0);
        step(4'b1110, 1, 0);
        step(4'b1100, 1, 0);
        step(4'b1000, 1, 0);
        step(4'b0000, 1, 0);
        step(4'b0001, 1, 0);
        step(4'b0011, 1, 0);
        // Illegal code while locked at phase 2, then relock on 1110
        step(4'b0101, 1, 0);
        step(4'b0111, 1, 0);
        step(4'b1111, 1, 0);
        step(4'b1110, 1, 0);
        step(4'b1100, 1, 0);
        step(4'b1000, 1, 0);
        step(4'b0000, 1, 0);
        step(4'b0001, 1, 0);
        step(4'b0011, 1, 0);
        step(4'b0111, 1, 0);
        // Skip from phase 3 to phase 5, then repeat phase 5
        step(4'b1110, 1, 0);
        step(4'b1110, 1, 0);
        step(4'b1011, 1, 0);
        step(4'b0000, 0, 0);

        // I_valid toggling every other cycle
        step(4'b0000, 0, 1);
        step(4'b0000, 1, 0);
        step(4'b0101, 0, 0);
        step(4'b0001, 1, 0);
        step(4'b1011, 0, 0);
        step(4'b0011, 1, 0);
        step(4'b0000, 0, 0);
        // Reset together with a valid sample
        step(4'b0111, 1, 1);
        step(4'b0000, 0, 0);

        // Random traffic
        for (int n = 0; n < 2000; n++) begin
            r  = $urandom_range(0, 99);
            r2 = $urandom_range(0, 99);
            if (r2 < 70)      c = (m_prev_ok) ? N'(ring[(m_prev + 1) % RING])
                                              : N'(ring[$urandom_range(0, RING - 1)]);
            else if (r2 < 80) c = N'(ring[$urandom_range(0, RING - 1)]);
            else if (r2 < 90) c = N'(ring[m_prev]);
            else              c = N'($urandom_range(0, (1 << N) - 1));
            v = ($urandom_range(0, 4) != 0);
            step(c, v, (r < 3));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/johnson_decoder.md
# johnson_decoder

Receive-side companion to the Johnson counter generators. Samples an N-bit Johnson-coded word, decodes it to a binary phase index, and checks that successive samples step exactly one position around the 2N-state ring. Lock, illegal-code and sequence-error status feed downstream clock-domain and phase-alignment logic that consumes Johnson-counter outputs.

## Interface
- N, default 4: Johnson code width; ring length 2N; N >= 2.
- LOCK_CNT, default 3: consecutive in-sequence legal samples required to assert lock; range 1..15.
- PW, derived, clog2(2N): phase width; 3 for N=4.

- CLK  in  1  clock; all state updates on rising edge.
- RESET  in  1  synchronous, active-high reset.
- I  in  N  Johnson-coded sample; I[0] is the shift-in end.
- I_valid  in  1  I is sampled this cycle.
- phase  out  PW  decoded phase index, 0..2N-1.
- phase_valid  out  1  one-cycle pulse; phase is valid.
- illegal  out  1  one-cycle pulse; sampled code is not a Johnson state.
- seq_err  out  1  one-cycle pulse; legal code is not the successor of the previous legal sample.
- locked  out  1  level; lock achieved.
- err_count  out  16  saturating error count; see Configuration.

## Operation
- Code map: phase k in 0..N is k low ones, rest zeros (0000, 0001, 0011, 0111, 1111 for N=4). Phase k in N+1..2N-1 is (k-N) low zeros, rest ones (1110, 1100, 1000).
- Decode: pc = popcount(I). If I[N-1]=0, phase = pc; else phase = 2N - pc, with 1111 giving N.
- Legality: I must equal the canonical pattern of its decoded phase. Any other pattern is illegal (e.g. 0101, 1011).
- Internal state: prev_phase (PW bits), prev_ok (1 bit), lock_ctr (4 bits), FSM {SEARCH, LOCKED}.
- On each I_valid sample:
  - Legal and prev_ok=0: phase_valid=1; lock_ctr=1; prev_ok=1.
  - Legal, prev_ok=1, phase == (prev_phase+1) mod 2N: phase_valid=1; lock_ctr increments, saturating at LOCK_CNT.
  - Legal, prev_ok=1, not the successor: phase_valid=1; seq_err=1; lock_ctr=1; FSM to SEARCH.
  - Illegal: illegal=1; phase_valid=0; phase holds its prior value; prev_ok=0; lock_ctr=0; FSM to SEARCH.
  - Repeated phase (no advance) counts as a sequence error.
- prev_phase updates on every legal sample.
- FSM: SEARCH to LOCKED when lock_ctr reaches LOCK_CNT on an in-sequence (or first) legal sample. LOCKED to SEARCH on any illegal or seq_err. locked = (FSM == LOCKED).
- Wrap-around: 2N-1 to 0 is a valid successor.
- I_valid=0: no state change; all pulse outputs 0.

## Timing
- Latency 1: a sample taken at edge t drives phase, phase_valid, illegal and seq_err during cycle t+1.
- locked asserts in the same cycle as the phase_valid of the qualifying sample.
- Reset values: phase=0, phase_valid=0, illegal=0, seq_err=0, locked=0, err_count=0, prev_ok=0, lock_ctr=0, FSM=SEARCH.
- RESET asserted while I_valid=1: RESET wins, and the sample is discarded.
- Reset mid-lock: locked drops on the cycle after the RESET edge, and the lock process restarts from scratch.
- illegal and seq_err are never high in the same cycle.

## Configuration
- JOHNSON_DEC_ERRCNT_EN defined: err_count increments by 1 on each cycle with illegal or seq_err high, saturating at 16'hFFFF. RESET clears it.
- JOHNSON_DEC_ERRCNT_EN undefined: the counter logic is absent, but the err_count port remains and is tied to 0.

## Test plan
- N=4, LOCK_CNT=3, continuous I_valid, codes 0000, 0001, 0011 -> phases 0, 1, 2; locked rises with the phase 2 pulse.
- Locked, feed the full ring through 1000 then 0000 -> phases 7 then 0, with no seq_err (wrap-around accepted).
- Locked at phase 2 (0011), inject 0101 -> illegal=1, locked=0, phase stays 2. Then 0111, 1111, 1110 -> relock on 1110.
- Locked at phase 3 (0111), inject 1110 (phase 5) -> seq_err=1, phase=5, locked=0. Repeated 1110 -> seq_err again.
- I_valid toggling every other cycle over 0000, 0001, 0011 -> locks with no errors. Assert RESET together with I_valid=1 -> all outputs 0 next cycle.
- With JOHNSON_DEC_ERRCNT_EN defined: 5 errors -> err_count=5, and RESET clears it to 0. Without the macro: err_count=0 throughout.
